// File: rtl/axis_output_manager.sv
// Request queue and header builder feeding the AXI-stream BRAM DMA top; one packet in flight at a time.
// Latency: push into an empty idle queue -> send_header 3 cycles later. Backpressure: req_ready low while the queue is full.
// Build option AXIS_OM_CHECKSUM_EN: header_word_4 carries an XOR checksum of the other words instead of the BRAM count.

module axis_om_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_push_dat,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head_dat,
    output logic             o_full,
    output logic             o_empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wptr;
    logic [AW:0]      r_rptr;
    logic             w_push;
    logic             w_pop;

    // Extra pointer bit distinguishes full from empty when the indices match.
    assign o_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign o_empty    = (r_wptr == r_rptr);
    assign w_push     = i_push && !o_full;
    assign w_pop      = i_pop && !o_empty;
    assign o_head_dat = r_mem[r_rptr[AW-1:0]];

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= i_push_dat;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
        end
    end
endmodule

module axis_output_manager #(
    parameter int          REQ_DEPTH      = 4,
    parameter logic [15:0] NOTIFY_LEN     = 16'd4,
    parameter int          GAP_CYCLES     = 4,
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [15:0] SYNC_WORD      = 16'hC0DE
) (
    input  logic        aclk,
    input  logic        areset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_type,
    input  logic [7:0]  req_layer_id,
    input  logic [2:0]  req_bram_end,
    input  logic [15:0] req_addr_count,
    output logic        send_header,
    output logic [15:0] header_word_0,
    output logic [15:0] header_word_1,
    output logic [15:0] header_word_2,
    output logic [15:0] header_word_3,
    output logic [15:0] header_word_4,
    output logic [15:0] header_word_5,
    output logic [2:0]  rd_bram_end,
    output logic [15:0] rd_addr_count,
    input  logic        read_done,
    output logic        busy,
    output logic [15:0] seq_num,
    output logic [15:0] pkts_sent,
    output logic        timeout_err,
    output logic        bad_req_err
);
    typedef struct packed {
        logic        typ;
        logic [7:0]  layer;
        logic [2:0]  bram_end;
        logic [15:0] count;
    } req_t;

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_LOAD      = 3'd1;
    localparam logic [2:0] S_TRIGGER   = 3'd2;
    localparam logic [2:0] S_WAIT_DONE = 3'd3;
    localparam logic [2:0] S_GAP       = 3'd4;

    logic [2:0]  r_state;
    logic [15:0] r_cnt;
    logic [15:0] r_seq;

    req_t        w_req_in;
    req_t        w_head;
    logic        w_full;
    logic        w_empty;
    logic        w_accept;
    logic        w_bad;
    logic        w_push;
    logic        w_pop;

    logic [2:0]  w_ld_end;
    logic [15:0] w_ld_count;
    logic [3:0]  w_bcnt;
    logic [18:0] w_prod;
    logic [15:0] w_w1;
    logic [15:0] w_w2;
    logic [15:0] w_w3;
    logic [15:0] w_w4;
    logic [15:0] w_w5;

    assign w_req_in  = {req_type, req_layer_id, req_bram_end, req_addr_count};
    assign req_ready = !w_full;
    assign w_accept  = req_valid && !w_full;
    // A zero-length data request would stall the DMA top, so it is dropped here.
    assign w_bad     = w_accept && !req_type && (req_addr_count == 16'd0);
    assign w_push    = w_accept && !w_bad;
    assign w_pop     = (r_state == S_LOAD);
    assign busy      = (r_state != S_IDLE) || !w_empty;
    assign seq_num   = r_seq;

    axis_om_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (REQ_DEPTH)
    ) u_req_fifo (
        .i_clk      (aclk),
        .i_rst      (areset),
        .i_push     (w_push),
        .i_push_dat (w_req_in),
        .i_pop      (w_pop),
        .o_head_dat (w_head),
        .o_full     (w_full),
        .o_empty    (w_empty)
    );

    assign w_ld_end   = w_head.typ ? 3'd0 : w_head.bram_end;
    assign w_ld_count = w_head.typ ? NOTIFY_LEN : w_head.count;
    assign w_bcnt     = {1'b0, w_ld_end} + 4'd1;
    assign w_prod     = {15'd0, w_bcnt} * {3'd0, w_ld_count};
    assign w_w1       = w_head.typ ? 16'd2 : 16'd1;
    assign w_w2       = {8'h00, w_head.layer};
    assign w_w3       = r_seq + 16'd1;
    assign w_w5       = (w_prod[18:16] != 3'd0) ? 16'hFFFF : w_prod[15:0];
`ifdef AXIS_OM_CHECKSUM_EN
    assign w_w4       = SYNC_WORD ^ w_w1 ^ w_w2 ^ w_w3 ^ w_w5;
`else
    assign w_w4       = {12'd0, w_bcnt};
`endif

    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state       <= S_IDLE;
            r_cnt         <= '0;
            r_seq         <= '0;
            send_header   <= 1'b0;
            header_word_0 <= '0;
            header_word_1 <= '0;
            header_word_2 <= '0;
            header_word_3 <= '0;
            header_word_4 <= '0;
            header_word_5 <= '0;
            rd_bram_end   <= '0;
            rd_addr_count <= '0;
            pkts_sent     <= '0;
            timeout_err   <= 1'b0;
        end else begin
            send_header <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!w_empty) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    header_word_0 <= SYNC_WORD;
                    header_word_1 <= w_w1;
                    header_word_2 <= w_w2;
                    header_word_3 <= w_w3;
                    header_word_4 <= w_w4;
                    header_word_5 <= w_w5;
                    rd_bram_end   <= w_ld_end;
                    rd_addr_count <= w_ld_count;
                    r_state       <= S_TRIGGER;
                end
                S_TRIGGER: begin
                    send_header <= 1'b1;
                    r_seq       <= w_w3;
                    r_cnt       <= '0;
                    r_state     <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (read_done) begin
                        pkts_sent <= pkts_sent + 16'd1;
                        r_cnt     <= '0;
                        r_state   <= S_GAP;
                    end else if (r_cnt == 16'(TIMEOUT_CYCLES - 1)) begin
                        timeout_err <= 1'b1;
                        r_cnt       <= '0;
                        r_state     <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                S_GAP: begin
                    // Quiet period lets the DMA top drop its auto-trigger latch before the next header.
                    if (r_cnt == 16'(GAP_CYCLES - 1)) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            bad_req_err <= 1'b0;
        end else if (w_bad) begin
            bad_req_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_output_manager.sv
`timescale 1ns/1ps
module tb_axis_output_manager;
    localparam int GAP = 4;

    logic        aclk = 1'b0;
    logic        areset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_type = 1'b0;
    logic [7:0]  req_layer_id = '0;
    logic [2:0]  req_bram_end = '0;
    logic [15:0] req_addr_count = '0;
    logic        send_header;
    logic [15:0] header_word_0, header_word_1, header_word_2, header_word_3, header_word_4, header_word_5;
    logic [2:0]  rd_bram_end;
    logic [15:0] rd_addr_count;
    logic        read_done = 1'b0;
    logic        busy;
    logic [15:0] seq_num;
    logic [15:0] pkts_sent;
    logic        timeout_err;
    logic        bad_req_err;

    typedef struct packed {
        logic        typ;
        logic [7:0]  layer;
        logic [2:0]  bend;
        logic [15:0] cnt;
    } tb_req_t;

    tb_req_t     exp_q[$];
    logic [15:0] model_seq = '0;
    logic [15:0] exp_pkts = '0;
    int          n_checks = 0;
    int          n_errs = 0;
    int          cyc = 0;

    initial forever #5 aclk = ~aclk;
    always @(posedge aclk) cyc <= cyc + 1;

    axis_output_manager dut (
        .aclk           (aclk),
        .areset         (areset),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_type       (req_type),
        .req_layer_id   (req_layer_id),
        .req_bram_end   (req_bram_end),
        .req_addr_count (req_addr_count),
        .send_header    (send_header),
        .header_word_0  (header_word_0),
        .header_word_1  (header_word_1),
        .header_word_2  (header_word_2),
        .header_word_3  (header_word_3),
        .header_word_4  (header_word_4),
        .header_word_5  (header_word_5),
        .rd_bram_end    (rd_bram_end),
        .rd_addr_count  (rd_addr_count),
        .read_done      (read_done),
        .busy           (busy),
        .seq_num        (seq_num),
        .pkts_sent      (pkts_sent),
        .timeout_err    (timeout_err),
        .bad_req_err    (bad_req_err)
    );

    // Reference: packet contents derived directly from the request and the packet's sequence number.
    function automatic logic [114:0] model_pkt(input tb_req_t r, input logic [15:0] seq);
        int n, cnt, prod;
        logic [15:0] w0, w1, w2, w3, w4, w5;
        n    = r.typ ? 1 : int'(r.bend) + 1;
        cnt  = r.typ ? 4 : int'(r.cnt);
        prod = n * cnt;
        w0 = 16'hC0DE;
        w1 = r.typ ? 16'd2 : 16'd1;
        w2 = 16'(r.layer);
        w3 = seq;
        w5 = (prod > 65535) ? 16'hFFFF : 16'(prod);
`ifdef AXIS_OM_CHECKSUM_EN
        w4 = w0 ^ w1 ^ w2 ^ w3 ^ w5;
`else
        w4 = 16'(n);
`endif
        return {w0, w1, w2, w3, w4, w5, 3'(n - 1), 16'(cnt)};
    endfunction

    function automatic logic [114:0] next_expected();
        tb_req_t r;
        if (exp_q.size() == 0) return {115{1'bx}};
        r = exp_q.pop_front();
        model_seq = model_seq + 16'd1;
        return model_pkt(r, model_seq);
    endfunction

    function automatic logic [114:0] got_pkt();
        return {header_word_0, header_word_1, header_word_2, header_word_3, header_word_4, header_word_5,
                rd_bram_end, rd_addr_count};
    endfunction

    task automatic push_req(input logic t, input logic [7:0] l, input logic [2:0] e, input logic [15:0] c);
        int guard;
        guard = 0;
        req_valid = 1'b1; req_type = t; req_layer_id = l; req_bram_end = e; req_addr_count = c;
        while (!req_ready && guard < 2000) begin
            @(negedge aclk);
            guard++;
        end
        if (!req_ready) begin
            n_checks++; n_errs++;
            $display("FAIL push_wait: req_ready stayed %0b, required 1 within 2000 cycles", req_ready);
        end else begin
            @(posedge aclk);
            if (!(t == 1'b0 && c == 16'd0)) exp_q.push_back('{t, l, e, c});
        end
        @(negedge aclk);
        req_valid = 1'b0;
    endtask

    task automatic wait_hdr(output int lat, input int budget);
        lat = -1;
        for (int i = 0; i < budget; i++) begin
            if (send_header) begin
                lat = i;
                break;
            end
            @(negedge aclk);
        end
    endtask

    task automatic pulse_done();
        read_done = 1'b1;
        @(negedge aclk);
        read_done = 1'b0;
    endtask

    task automatic test_reset();
        areset = 1'b1;
        repeat (3) @(negedge aclk);
        n_checks++;
        if ({send_header, req_ready, busy, seq_num, pkts_sent, timeout_err, bad_req_err} !== {1'b0, 1'b1, 1'b0, 32'd0, 2'b00}) begin
            n_errs++;
            $display("FAIL reset_ctrl: got sh=%0b rdy=%0b busy=%0b seq=%0d pk=%0d to=%0b bad=%0b, required 0 1 0 0 0 0 0",
                     send_header, req_ready, busy, seq_num, pkts_sent, timeout_err, bad_req_err);
        end
        n_checks++;
        if (got_pkt() !== '0) begin
            n_errs++;
            $display("FAIL reset_hdr: got %h, required 0", got_pkt());
        end
        areset = 1'b0;
        @(negedge aclk);
    endtask

    task automatic test_packets(input logic t, input int n);
        int lat;
        logic [114:0] e;
        logic [7:0] l;
        logic [2:0] be;
        logic [15:0] c;
        for (int i = 0; i < n; i++) begin
            l = 8'($urandom); be = 3'($urandom); c = 16'($urandom_range(1, 65535));
            if (i == 0) begin
                l = t ? 8'd9 : 8'd3; be = 3'd7; c = 16'd512;
            end
            push_req(t, l, be, c);
            wait_hdr(lat, 20);
            n_checks++;
            if (lat != 3) begin
                n_errs++;
                $display("FAIL latency: got %0d cycles, required 3", lat);
            end
            if (lat >= 0) begin
                e = next_expected();
                n_checks++;
                if (got_pkt() !== e) begin
                    n_errs++;
                    $display("FAIL pkt_single: got %h, required %h", got_pkt(), e);
                end
                n_checks++;
                if (seq_num !== model_seq) begin
                    n_errs++;
                    $display("FAIL seq_num: got %0d, required %0d", seq_num, model_seq);
                end
            end
            repeat ($urandom_range(0, 5)) @(negedge aclk);
            pulse_done();
            exp_pkts = exp_pkts + 16'd1;
            repeat (GAP + 4) @(negedge aclk);
            n_checks++;
            if ({pkts_sent, busy} !== {exp_pkts, 1'b0}) begin
                n_errs++;
                $display("FAIL pkts_idle: got pkts=%0d busy=%0b, required %0d 0", pkts_sent, busy, exp_pkts);
            end
        end
    endtask

    task automatic test_done_filtering();
        logic [114:0] e;
        pulse_done();
        repeat (3) @(negedge aclk);
        n_checks++;
        if (pkts_sent !== exp_pkts) begin
            n_errs++;
            $display("FAIL done_idle: pkts got %0d, required %0d", pkts_sent, exp_pkts);
        end
        push_req(1'b0, 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        repeat (2) @(negedge aclk);
        read_done = 1'b1;   // lands on the TRIGGER edge
        @(negedge aclk);
        read_done = 1'b0;
        n_checks++;
        if (send_header !== 1'b1) begin
            n_errs++;
            $display("FAIL trig_timing: send_header got %0b, required 1", send_header);
        end
        e = next_expected();
        n_checks++;
        if (got_pkt() !== e) begin
            n_errs++;
            $display("FAIL pkt_filter: got %h, required %h", got_pkt(), e);
        end
        repeat (5) @(negedge aclk);
        n_checks++;
        if ({pkts_sent, busy} !== {exp_pkts, 1'b1}) begin
            n_errs++;
            $display("FAIL done_trigger: got pkts=%0d busy=%0b, required %0d 1", pkts_sent, busy, exp_pkts);
        end
        pulse_done();
        exp_pkts = exp_pkts + 16'd1;
        repeat (GAP + 4) @(negedge aclk);
        n_checks++;
        if (pkts_sent !== exp_pkts) begin
            n_errs++;
            $display("FAIL done_wait: pkts got %0d, required %0d", pkts_sent, exp_pkts);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int done_cyc;
        logic [114:0] e;
        push_req(1'b0, 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        wait_hdr(lat, 20);
        e = next_expected();
        n_checks++;
        if (lat < 0 || got_pkt() !== e) begin
            n_errs++;
            $display("FAIL b2b_first: lat=%0d got %h, required %h", lat, got_pkt(), e);
        end
        for (int i = 0; i < 4; i++) push_req(1'($urandom), 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        n_checks++;
        if ({req_ready, busy} !== 2'b01) begin
            n_errs++;
            $display("FAIL fifo_full: got ready=%0b busy=%0b, required 0 1", req_ready, busy);
        end
        fork
            push_req(1'($urandom), 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
            begin
                done_cyc = cyc;
                pulse_done();
                exp_pkts = exp_pkts + 16'd1;
                for (int k = 0; k < 5; k++) begin
                    wait_hdr(lat, 100);
                    n_checks++;
                    if (lat < 0) begin
                        n_errs++;
                        $display("FAIL b2b_hdr: packet %0d got no send_header, required one", k);
                    end else begin
                        n_checks++;
                        if (cyc - done_cyc < GAP + 2) begin
                            n_errs++;
                            $display("FAIL b2b_gap: got %0d cycles after read_done, required >= %0d", cyc - done_cyc, GAP + 2);
                        end
                        e = next_expected();
                        n_checks++;
                        if (got_pkt() !== e) begin
                            n_errs++;
                            $display("FAIL b2b_pkt: packet %0d got %h, required %h", k, got_pkt(), e);
                        end
                    end
                    repeat ($urandom_range(1, 3)) @(negedge aclk);
                    done_cyc = cyc;
                    pulse_done();
                    exp_pkts = exp_pkts + 16'd1;
                end
            end
        join
        repeat (GAP + 4) @(negedge aclk);
        n_checks++;
        if ({pkts_sent, busy} !== {exp_pkts, 1'b0}) begin
            n_errs++;
            $display("FAIL b2b_end: got pkts=%0d busy=%0b, required %0d 0", pkts_sent, busy, exp_pkts);
        end
    endtask

    task automatic test_saturation_bad();
        int lat;
        logic [114:0] e;
        for (int i = 0; i < 4; i++) begin
            if (i == 0) push_req(1'b0, 8'd1, 3'd7, 16'hFFFF);
            else if (i == 3) push_req(1'b1, 8'd5, 3'd6, 16'd0);
            else push_req(1'b0, 8'($urandom), 3'($urandom_range(1, 7)), 16'($urandom_range(8192, 65535)));
            wait_hdr(lat, 20);
            e = next_expected();
            n_checks++;
            if (lat < 0 || got_pkt() !== e) begin
                n_errs++;
                $display("FAIL sat_pkt: case %0d lat=%0d got %h, required %h", i, lat, got_pkt(), e);
            end
            pulse_done();
            exp_pkts = exp_pkts + 16'd1;
            repeat (GAP + 4) @(negedge aclk);
        end
        n_checks++;
        if (bad_req_err !== 1'b0) begin
            n_errs++;
            $display("FAIL bad_pre: bad_req_err got %0b, required 0", bad_req_err);
        end
        push_req(1'b0, 8'd2, 3'd3, 16'd0);
        wait_hdr(lat, 20);
        n_checks++;
        if (lat != -1 || {bad_req_err, busy} !== 2'b10) begin
            n_errs++;
            $display("FAIL bad_req: lat=%0d bad=%0b busy=%0b, required no header, 1, 0", lat, bad_req_err, busy);
        end
    endtask

    task automatic test_timeout();
        int lat;
        logic [114:0] e;
        push_req(1'b0, 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        wait_hdr(lat, 20);
        e = next_expected();
        n_checks++;
        if (lat < 0 || got_pkt() !== e) begin
            n_errs++;
            $display("FAIL to_first: lat=%0d got %h, required %h", lat, got_pkt(), e);
        end
        push_req(1'b1, 8'($urandom), 3'($urandom), 16'($urandom));
        repeat (65000) @(negedge aclk);
        n_checks++;
        if (timeout_err !== 1'b0) begin
            n_errs++;
            $display("FAIL to_early: timeout_err got %0b, required 0", timeout_err);
        end
        for (int i = 0; i < 1000 && !timeout_err; i++) @(negedge aclk);
        n_checks++;
        if ({timeout_err, pkts_sent} !== {1'b1, exp_pkts}) begin
            n_errs++;
            $display("FAIL to_fire: got to=%0b pkts=%0d, required 1 %0d", timeout_err, pkts_sent, exp_pkts);
        end
        wait_hdr(lat, 50);
        e = next_expected();
        n_checks++;
        if (lat < 0 || got_pkt() !== e) begin
            n_errs++;
            $display("FAIL to_next: lat=%0d got %h, required %h", lat, got_pkt(), e);
        end
        pulse_done();
        exp_pkts = exp_pkts + 16'd1;
        repeat (GAP + 4) @(negedge aclk);
        n_checks++;
        if ({timeout_err, pkts_sent, busy} !== {1'b1, exp_pkts, 1'b0}) begin
            n_errs++;
            $display("FAIL to_sticky: got to=%0b pkts=%0d busy=%0b, required 1 %0d 0", timeout_err, pkts_sent, busy, exp_pkts);
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [114:0] e;
        push_req(1'b0, 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        wait_hdr(lat, 20);
        push_req(1'b0, 8'($urandom), 3'($urandom), 16'($urandom_range(1, 65535)));
        push_req(1'b1, 8'($urandom), 3'($urandom), 16'($urandom));
        repeat (3) @(negedge aclk);
        areset = 1'b1;
        @(negedge aclk);
        n_checks++;
        if ({send_header, req_ready, busy, seq_num, pkts_sent, timeout_err, bad_req_err} !== {1'b0, 1'b1, 1'b0, 32'd0, 2'b00}
            || got_pkt() !== '0) begin
            n_errs++;
            $display("FAIL rst_flight: got rdy=%0b busy=%0b seq=%0d pk=%0d to=%0b bad=%0b hdr=%h, required all 0 except rdy=1",
                     req_ready, busy, seq_num, pkts_sent, timeout_err, bad_req_err, got_pkt());
        end
        areset = 1'b0;
        exp_q.delete();
        model_seq = '0;
        exp_pkts = '0;
        wait_hdr(lat, 20);
        n_checks++;
        if (lat != -1 || busy !== 1'b0) begin
            n_errs++;
            $display("FAIL rst_flush: lat=%0d busy=%0b, required no header and busy 0", lat, busy);
        end
        push_req(1'b0, 8'd3, 3'd7, 16'd512);
        wait_hdr(lat, 20);
        e = next_expected();
        n_checks++;
        if (lat != 3 || got_pkt() !== e || seq_num !== 16'd1) begin
            n_errs++;
            $display("FAIL rst_restart: lat=%0d seq=%0d got %h, required lat 3 seq 1 %h", lat, seq_num, got_pkt(), e);
        end
        pulse_done();
        repeat (GAP + 4) @(negedge aclk);
    endtask

    initial begin
        @(negedge aclk);
        test_reset();
        test_packets(1'b0, 6);
        test_packets(1'b1, 4);
        test_done_filtering();
        test_back_to_back();
        test_saturation_bad();
        test_timeout();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
